// File: rtl/mmio_led_pwm.sv
// Memory-mapped LED / RGB PWM peripheral with a free-running millisecond counter.
// Sits on the data-memory bus; reads return registered data one cycle after the request.
module mmio_led_pwm #(
  parameter int unsigned CLK_HZ   = 12000000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        LED,
  output logic        RGB_R,
  output logic        RGB_G,
  output logic        RGB_B
);

  localparam int unsigned TickDiv = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int unsigned PresW   = ($clog2(TickDiv) < 1) ? 1 : $clog2(TickDiv);
  localparam logic [PresW-1:0]    PresMax = PresW'(TickDiv - 1);
  localparam logic [PWM_BITS-1:0] PwmMax  = '1;

  logic [1:0]          ctrl_q;
  logic [PWM_BITS-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic [PWM_BITS-1:0] shadow_r_q, shadow_g_q, shadow_b_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [31:0]         millis_q;
  logic                status_q;
  logic [PresW-1:0]    presc_q;
  logic [31:0]         rdata_q;

  logic [2:0]  idx;
  logic        rd_en, wr_en;
  logic        wr_ctrl, wr_duty_r, wr_duty_g, wr_duty_b, wr_millis, wr_status;
  logic        tick;
  logic        pwm_en;
  logic [31:0] rd_val;
  logic [1:0]  unused_addr;

  // Byte lanes within a word are not decoded.
  assign unused_addr = addr[1:0];

  always_comb begin
    idx       = addr[4:2];
    rd_en     = sel & ~we;
    wr_en     = sel & we;
    wr_ctrl   = wr_en & (idx == 3'd0);
    wr_duty_r = wr_en & (idx == 3'd1);
    wr_duty_g = wr_en & (idx == 3'd2);
    wr_duty_b = wr_en & (idx == 3'd3);
    wr_millis = wr_en & (idx == 3'd4);
    wr_status = wr_en & (idx == 3'd5);
    tick      = (presc_q == PresMax);
    pwm_en    = ctrl_q[1];
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      3'd0:    rd_val = {30'b0, ctrl_q};
      3'd1:    rd_val = 32'(duty_r_q);
      3'd2:    rd_val = 32'(duty_g_q);
      3'd3:    rd_val = 32'(duty_b_q);
      3'd4:    rd_val = millis_q;
      3'd5:    rd_val = {31'b0, status_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q     <= '0;
      duty_r_q   <= '0;
      duty_g_q   <= '0;
      duty_b_q   <= '0;
      shadow_r_q <= '0;
      shadow_g_q <= '0;
      shadow_b_q <= '0;
      pwm_cnt_q  <= '0;
      millis_q   <= '0;
      status_q   <= 1'b0;
      presc_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (rd_en) rdata_q <= rd_val;

      if (wr_ctrl)   ctrl_q   <= wdata[1:0];
      if (wr_duty_r) duty_r_q <= wdata[PWM_BITS-1:0];
      if (wr_duty_g) duty_g_q <= wdata[PWM_BITS-1:0];
      if (wr_duty_b) duty_b_q <= wdata[PWM_BITS-1:0];

      // A firmware write to MILLIS beats a coincident tick increment.
      if (wr_millis)  millis_q <= wdata;
      else if (tick)  millis_q <= millis_q + 32'd1;

      if (wr_millis || tick) presc_q <= '0;
      else                   presc_q <= presc_q + PresW'(1);

      if (tick)           status_q <= 1'b1;
      else if (wr_status) status_q <= 1'b0;

      // Shadows only reload at the period boundary; disabled PWM reloads every cycle.
      if (!pwm_en) begin
        pwm_cnt_q  <= '0;
        shadow_r_q <= duty_r_q;
        shadow_g_q <= duty_g_q;
        shadow_b_q <= duty_b_q;
      end else begin
        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        if (pwm_cnt_q == PwmMax) begin
          shadow_r_q <= duty_r_q;
          shadow_g_q <= duty_g_q;
          shadow_b_q <= duty_b_q;
        end
      end
    end
  end

  always_comb begin
    rdata = rdata_q;
    LED   = ctrl_q[0];
    RGB_R = ~(pwm_en & (pwm_cnt_q < shadow_r_q));
    RGB_G = ~(pwm_en & (pwm_cnt_q < shadow_g_q));
    RGB_B = ~(pwm_en & (pwm_cnt_q < shadow_b_q));
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Bench for mmio_led_pwm: directed scenarios plus random bus traffic, all checked every
// cycle against a behavioural model of the register map, millisecond timer and PWM.
module tb_mmio_led_pwm;

  localparam int unsigned Div    = 4;
  localparam int          Period = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        LED, RGB_R, RGB_G, RGB_B;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  int low_r, low_g, low_b;

  // Model state.
  logic [31:0] m_rdata, m_millis;
  logic [1:0]  m_ctrl;
  logic        m_status;
  logic [7:0]  m_duty[3];
  logic [7:0]  m_shadow[3];
  int          m_presc, m_pwm;

  mmio_led_pwm #(.CLK_HZ(4000), .PWM_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .LED   (LED),
    .RGB_R (RGB_R),
    .RGB_G (RGB_G),
    .RGB_B (RGB_B)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_rgb(int i);
    return !(m_ctrl[1] && (m_pwm < int'(m_shadow[i])));
  endfunction

  task automatic model_step(bit rn, bit s, bit w, int idx, logic [31:0] d);
    logic [31:0] rv;
    bit tick;
    if (!rn) begin
      m_rdata = 0; m_millis = 0; m_ctrl = 0; m_status = 0; m_presc = 0; m_pwm = 0;
      for (int i = 0; i < 3; i++) begin m_duty[i] = 0; m_shadow[i] = 0; end
      return;
    end
    case (idx)
      0:       rv = {30'b0, m_ctrl};
      1, 2, 3: rv = {24'b0, m_duty[idx-1]};
      4:       rv = m_millis;
      5:       rv = {31'b0, m_status};
      default: rv = 0;
    endcase
    if (s && !w) m_rdata = rv;
    tick = (m_presc == Div - 1);
    if (!m_ctrl[1]) begin
      m_pwm = 0;
      for (int i = 0; i < 3; i++) m_shadow[i] = m_duty[i];
    end else begin
      m_pwm = (m_pwm + 1) % Period;
      if (m_pwm == 0) for (int i = 0; i < 3; i++) m_shadow[i] = m_duty[i];
    end
    if (s && w && idx == 4) begin
      m_millis = d;
      m_presc  = 0;
    end else begin
      if (tick) m_millis = m_millis + 1;
      m_presc = (m_presc + 1) % Div;
    end
    if (tick) m_status = 1;
    else if (s && w && idx == 5) m_status = 0;
    if (s && w && idx == 0) m_ctrl = d[1:0];
    if (s && w && idx >= 1 && idx <= 3) m_duty[idx-1] = d[7:0];
  endtask

  // Inputs change just after the falling edge; outputs have no combinational input path.
  task automatic step(bit rn, bit s, bit w, int idx, logic [31:0] d);
    reset = rn; sel = s; we = w; wdata = d;
    addr  = 5'(idx * 4 + int'($urandom_range(0, 3)));
    @(posedge clk);
    model_step(rn, s, w, idx, d);
    @(negedge clk);
    if (!RGB_R) low_r++;
    if (!RGB_G) low_g++;
    if (!RGB_B) low_b++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
  endtask

  task automatic wr(int idx, logic [31:0] d);
    step(1, 1, 1, idx, d);
  endtask

  task automatic rd(int idx);
    step(1, 1, 0, idx, 0);
  endtask

  task automatic align_presc(int t);
    int n = 0;
    while (m_presc != t && n < 20) begin idle(1); n++; end
    check("align_presc", 32'(m_presc), 32'(t));
  endtask

  task automatic align_pwm(int t);
    int n = 0;
    while (m_pwm != t && n < 600) begin idle(1); n++; end
    check("align_pwm", 32'(m_pwm), 32'(t));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("rdata", rdata, m_rdata);
      check("led", 32'(LED), 32'(m_ctrl[0]));
      check("rgb_r", 32'(RGB_R), 32'(exp_rgb(0)));
      check("rgb_g", 32'(RGB_G), 32'(exp_rgb(1)));
      check("rgb_b", 32'(RGB_B), 32'(exp_rgb(2)));
    end
  end

  initial begin
    int order[8] = '{4, 5, 0, 1, 2, 3, 6, 7};
    int r;

    @(negedge clk);
    step(0, 0, 0, 0, 0);
    chk_on = 1'b1;
    step(0, 0, 0, 0, 0);
    check("rst_rdata", rdata, 0);
    check("rst_led", 32'(LED), 0);
    check("rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h7);
    for (int i = 0; i < 8; i++) begin
      rd(order[i]);
      check($sformatf("rst_read%0d", order[i]), rdata, 0);
    end

    wr(0, 32'h1);
    check("led_on", 32'(LED), 1);
    rd(0);
    check("ctrl_read", rdata, 32'h1);
    wr(0, 32'h0);
    check("led_off", 32'(LED), 0);

    step(0, 0, 0, 0, 0);
    idle(40);
    rd(4);
    check("millis_40", rdata, 32'd10);
    rd(5);
    check("status_set", rdata, 32'd1);
    wr(5, 0);
    rd(5);
    check("status_clr", rdata, 32'd0);
    wr(4, 32'hFFFF_FFFF);
    idle(4);
    rd(4);
    check("millis_wrap", rdata, 32'd0);

    align_presc(Div - 1);
    wr(4, 32'h100);
    rd(4);
    check("millis_wr_wins", rdata, 32'h100);
    idle(2);
    rd(4);
    check("millis_hold", rdata, 32'h100);
    rd(4);
    check("millis_next", rdata, 32'h101);

    wr(1, 64); wr(2, 0); wr(3, 255); wr(0, 32'h2);
    align_pwm(Period - 1);
    low_r = 0; low_g = 0; low_b = 0;
    idle(Period);
    check("low_r_64", 32'(low_r), 64);
    check("low_g_0", 32'(low_g), 0);
    check("low_b_255", 32'(low_b), 255);

    align_pwm(Period - 1);
    low_r = 0;
    idle(10);
    wr(1, 128);
    idle(Period - 11);
    check("low_r_old", 32'(low_r), 64);
    low_r = 0;
    idle(Period);
    check("low_r_new", 32'(low_r), 128);

    align_pwm(20);
    check("r_lit_mid", 32'(RGB_R), 0);
    step(0, 1, 0, 4, 0);
    check("r_off_rst", 32'(RGB_R), 1);
    check("rd_rst", rdata, 0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      else step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_led_pwm.md
Name: mmio_led_pwm

Overview:
- Memory-mapped I/O peripheral on the data-memory bus of the multicycle RV32I core, downstream of the core's load/store path.
- Drives the board LED and the RGB_R/RGB_G/RGB_B pins through 8-bit PWM.
- Provides a free-running millisecond counter that firmware reads for delays.
- The top-level address decoder asserts sel when the address falls in the peripheral window; reads return data one cycle later, matching the core's memory read timing.

Parameters:
- CLK_HZ, 12000000, input clock frequency; the millisecond tick period is CLK_HZ/1000 cycles (minimum 1).
- PWM_BITS, 8, width of the PWM counter and duty registers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- sel  input  1  peripheral selected for this bus cycle.
- we  input  1  write enable; valid when sel=1.
- addr  input  5  byte offset; addr[4:2] is the register index, addr[1:0] is ignored.
- wdata  input  32  write data.
- rdata  output  32  registered read data.
- LED  output  1  user LED, active-high.
- RGB_R  output  1  red PWM output, active-low (0 = lit).
- RGB_G  output  1  green PWM output, active-low.
- RGB_B  output  1  blue PWM output, active-low.

Behaviour:
- Register map, by index:
  - 0 CTRL (RW): bit0 drives LED; bit1 is PWM_EN; other bits read 0.
  - 1 DUTY_R (RW, [PWM_BITS-1:0]).
  - 2 DUTY_G (RW).
  - 3 DUTY_B (RW).
  - 4 MILLIS (RW, 32 bits).
  - 5 STATUS (RO): bit0 is a sticky tick flag, cleared by any write to index 5.
  - 6-7 unmapped: read 0, writes ignored.
- Reset values (on the edge where reset=0): all registers 0, pwm_cnt 0, prescaler 0, rdata 0, LED 0, RGB_* 1 (off).
- Writes (sel=1 and we=1):
  - The register updates at that clock edge.
  - Written data is visible to a read issued on the next cycle.
- Reads (sel=1 and we=0):
  - rdata holds the register value sampled at the edge, valid one cycle later.
  - rdata holds its value while sel=0.
  - A read and a write to the same register in the same cycle is impossible (we selects one).
- Prescaler:
  - Counts 0..CLK_HZ/1000-1.
  - At terminal count it wraps to 0, pulses tick for one cycle, increments MILLIS (32-bit wrap, 0xFFFFFFFF -> 0), and sets STATUS.bit0.
- MILLIS write:
  - MILLIS takes wdata and the prescaler clears to 0.
  - If a tick coincides, the write wins and no increment occurs that cycle.
- STATUS clear coinciding with a tick: the set wins, so the flag stays 1.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps.
  - Each colour has a shadow duty, loaded from DUTY_x only when pwm_cnt wraps to 0. No glitch mid-period.
  - Output is lit (0) when PWM_EN=1 and pwm_cnt < shadow_duty.
  - Duty 0 is never lit. Duty 255 is lit 255 of 256 cycles.
  - With PWM_EN=0: all RGB_* = 1 and pwm_cnt is held at 0; shadow registers load on the next cycle.
- LED follows CTRL.bit0 combinationally from the register (one cycle after the write edge).
- Reset asserted mid-operation: everything returns to reset values on that edge and an in-flight read returns 0.

Test Plan:
- Reset held low 2 cycles, then released -> rdata=0, LED=0, RGB_R/G/B=1; read of every index returns 0.
- Write CTRL=0x1, then read index 0 -> LED=1 on the cycle after the write; rdata=0x00000001 one cycle after the read. Write CTRL=0 -> LED=0.
- CLK_HZ=4000 (tick every 4 cycles): run 40 cycles -> MILLIS=10 and STATUS.bit0=1. Write STATUS -> reads 0 until the next tick. Write MILLIS=0xFFFFFFFF, wait 4 cycles -> MILLIS=0.
- Write MILLIS=0x100 on the exact tick cycle -> MILLIS reads 0x100, not 0x101; the next increment comes 4 cycles later.
- CTRL=0x2, DUTY_R=64, DUTY_G=0, DUTY_B=255 -> over a full 256-cycle period after the next wrap: RGB_R low 64 cycles, RGB_G never low, RGB_B low 255 cycles.
- Change DUTY_R from 64 to 128 at pwm_cnt=10 -> the current period still shows 64 low cycles; the next period shows 128. Assert reset mid-period -> RGB_R=1 on the following cycle.
